// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable clock divider: default sizing
// and the high-phase length of a divided period.
package freq_div_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 4;
    localparam int FN_W            = 32;

    // High phase of an N-cycle period is ceil(N/2); zero for a disabled channel.
    function automatic logic [FN_W-1:0] high_len(input logic [FN_W-1:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: phase counter, active/shadow ratio pair and
// registered clock level / tick outputs.
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             load,
    input  logic [CNT_W-1:0] ratio,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             pending
);

    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_p1, cnt_d;
    logic             clk_p1, clk_d;
    logic             tick_p1, tick_d;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             wrap;
    logic [CNT_W-1:0] n_eff;
    logic [FN_W-1:0]  h_full;

    always_comb begin
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        cnt_d    = '0;
        clk_d    = 1'b0;
        tick_d   = 1'b0;
        run_d    = 1'b0;
        wrap     = 1'b0;
        n_eff    = active_q;
        h_full   = '0;

        if (active_q == '0) begin
            pend_d = 1'b0;
            if (load) active_d = ratio;
        end else if (!start) begin
            // A stop is also a period boundary for any queued ratio.
            pend_d = 1'b0;
            if (load)        active_d = ratio;
            else if (pend_q) active_d = shadow_q;
        end else begin
            wrap = !run_q || (cnt_q_is_last());
            if (wrap) begin
                n_eff    = load ? ratio : (pend_q ? shadow_q : active_q);
                active_d = n_eff;
                pend_d   = 1'b0;
            end else begin
                cnt_d = cnt_p1 + 1'b1;
                if (load) begin
                    shadow_d = ratio;
                    pend_d   = 1'b1;
                end
            end
            // A zero ratio applied at the wrap disables the channel from here.
            run_d  = (n_eff != '0);
            h_full = high_len(FN_W'(n_eff));
            clk_d  = (FN_W'(cnt_d) < h_full);
            tick_d = run_d && (cnt_d == n_eff - 1'b1);
        end
    end

    function automatic logic cnt_q_is_last();
        return cnt_p1 == active_q - 1'b1;
    endfunction

    // ---- output / state register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= CNT_W'(DEFAULT_DIV);
            shadow_q <= CNT_W'(DEFAULT_DIV);
            cnt_p1   <= '0;
            clk_p1   <= 1'b0;
            tick_p1  <= 1'b0;
            pend_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            shadow_q <= shadow_d;
            cnt_p1   <= cnt_d;
            clk_p1   <= clk_d;
            tick_p1  <= tick_d;
            pend_q   <= pend_d;
            run_q    <= run_d;
        end
    end

    assign clk_out = clk_p1;
    assign tick    = tick_p1;
    assign count   = cnt_p1;
    assign pending = pend_q;

endmodule

// File: rtl/freq_divider_prog.sv
// Multi-channel programmable clock divider: independent channels,
// each with its own ratio bus slice, enable and load strobe.
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       ratio_load,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       pending
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        freq_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start[gi]),
            .load    (ratio_load[gi]),
            .ratio   (div_ratio[gi*CNT_W +: CNT_W]),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi]),
            .count   (count[gi*CNT_W +: CNT_W]),
            .pending (pending[gi])
        );
    end

endmodule

// File: tb/tb_freq_divider_prog.sv
// Scoreboard bench for freq_divider_prog: the driver queues hand-computed
// per-cycle expectations, a monitor pops and compares after each edge.
module tb_freq_divider_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  start = '0;
    logic [1:0]  ratio_load = '0;
    logic [15:0] div_ratio = '0;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [15:0] count;
    logic [1:0]  pending;

    freq_divider_prog #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ratio_load (ratio_load),
        .div_ratio  (div_ratio),
        .clk_out    (clk_out),
        .tick       (tick),
        .count      (count),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] tag;
        logic [1:0]  oclk;
        logic [1:0]  otick;
        logic [1:0]  opend;
        logic [7:0]  c0;
        logic [7:0]  c1;
    } exp_t;

    exp_t q[$];
    int   vec = 0;
    logic done = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cyc(input logic [1:0] s, input logic [1:0] l,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] ec, input logic [1:0] et,
                       input logic [1:0] ep, input logic [7:0] e0,
                       input logic [7:0] e1);
        exp_t x;
        @(negedge clk);
        start      = s;
        ratio_load = l;
        div_ratio  = {b, a};
        vec++;
        x = '{tag: 16'(vec), oclk: ec, otick: et, opend: ep, c0: e0, c1: e1};
        q.push_back(x);
    endtask

    // Channel 0 only; channel 1 held stopped, so its outputs stay zero.
    task automatic v0(input logic s, input logic l, input logic [7:0] r,
                      input logic c, input logic t, input logic p,
                      input logic [7:0] n);
        cyc({1'b0, s}, {1'b0, l}, r, 8'd0, {1'b0, c}, {1'b0, t},
            {1'b0, p}, n, 8'd0);
    endtask

    task automatic check(input exp_t x);
        exp_t a;
        a = '{tag: x.tag, oclk: clk_out, otick: tick, opend: pending,
              c0: count[7:0], c1: count[15:8]};
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL v%0d: got clk_out=%b tick=%b pending=%b count0=%0d count1=%0d, want clk_out=%b tick=%b pending=%b count0=%0d count1=%0d",
                     x.tag, a.oclk, a.otick, a.opend, a.c0, a.c1,
                     x.oclk, x.otick, x.opend, x.c0, x.c1);
        end
    endtask

    // Monitor: queued expectation after each edge; all-zero while in reset.
    initial begin
        int post = 0;
        exp_t z;
        z = '{tag: 16'hFFFF, oclk: 2'b00, otick: 2'b00, opend: 2'b00, c0: 8'd0, c1: 8'd0};
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) check(q.pop_front());
            else if (!rst_n)  check(z);
            if (done) begin
                if (q.size() == 0) break;
                post++;
                if (post > 5) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL drain: got %0d queued, want 0", q.size());
                    break;
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // N=4 default: 1,1,0,0 with tick at count 3
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,0,0,2); v0(1,0,0, 0,1,0,3);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,0,0,2); v0(1,0,0, 0,1,0,3);

        // Load N=2 mid-period: pending until the wrap, then 1,0
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,1,2, 0,0,1,2); v0(1,0,0, 0,1,1,3);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 0,1,0,1); v0(1,0,0, 1,0,0,0); v0(1,0,0, 0,1,0,1);
        v0(0,0,0, 0,0,0,0);

        // N=3 loaded while stopped
        v0(0,1,3, 0,0,0,0);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,1,0,2);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,1,0,2);

        // N=1: clk_out and tick held high
        v0(0,0,0, 0,0,0,0); v0(0,1,1, 0,0,0,0);
        v0(1,0,0, 1,1,0,0); v0(1,0,0, 1,1,0,0); v0(1,0,0, 1,1,0,0);

        // N=0 disables regardless of start; load 5 applies immediately
        v0(0,1,0, 0,0,0,0); v0(1,0,0, 0,0,0,0); v0(1,0,0, 0,0,0,0);
        v0(1,1,5, 0,0,0,0);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 1,0,0,2);
        v0(1,0,0, 0,0,0,3); v0(1,0,0, 0,1,0,4); v0(1,0,0, 1,0,0,0);

        // Stop with pending ratio 4: applied on the stop edge
        v0(1,1,4, 1,0,1,1); v0(0,0,0, 0,0,0,0);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,0,0,2);
        v0(1,0,0, 0,1,0,3); v0(1,0,0, 1,0,0,0);

        // Stop at count 2, restart, then load 6 and start before reset
        v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,0,0,2); v0(0,0,0, 0,0,0,0);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(0,1,6, 0,0,0,0);
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 1,0,0,2);

        // Async reset mid-period; ratio returns to 4
        @(negedge clk);
        rst_n = 1'b0;
        start = 2'b00;
        ratio_load = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        v0(1,0,0, 1,0,0,0); v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,0,0,2); v0(1,0,0, 0,1,0,3);

        // Load on the wrap edge applies directly; later load overrides a pending one
        v0(1,1,2, 1,0,0,0); v0(1,0,0, 0,1,0,1); v0(1,0,0, 1,0,0,0);
        v0(1,1,5, 0,1,1,1); v0(1,1,3, 1,0,0,0);
        v0(1,0,0, 1,0,0,1); v0(1,0,0, 0,1,0,2); v0(1,0,0, 1,0,0,0);

        // Two channels: ch0 N=4, ch1 N=6 then ch1 reloaded to 2
        cyc(2'b00, 2'b10, 8'd0, 8'd6, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
        cyc(2'b00, 2'b01, 8'd4, 8'd0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 8'd1, 8'd1);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 2'b00, 8'd2, 8'd2);
        cyc(2'b11, 2'b10, 8'd0, 8'd2, 2'b00, 2'b01, 2'b10, 8'd3, 8'd3);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b10, 8'd0, 8'd4);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b01, 2'b10, 2'b10, 8'd1, 8'd5);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 2'b00, 8'd2, 8'd0);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00, 8'd3, 8'd1);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
        cyc(2'b11, 2'b00, 8'd0, 8'd0, 2'b01, 2'b10, 2'b00, 8'd1, 8'd1);

        @(negedge clk);
        start = 2'b00;
        done  = 1'b1;
    end

endmodule

// File: doc/freq_divider_prog.md
Name: freq_divider_prog

Overview:
Multi-channel, runtime-programmable integer clock divider. Successor to the fixed 2-bit start-driven divider: generalised counter width, per-channel divide ratio and enable, a glitch-free ratio update at period boundaries, and a single-cycle tick per output period. Outputs are registered divided-clock levels and clock-enable ticks in the clk domain, intended for driving slow peripherals and timers.

Parameters:
NUM_CH, 2, number of independent divider channels
CNT_W, 8, width of the divide ratio and the counter (max ratio 2^CNT_W-1)
DEFAULT_DIV, 4, ratio loaded into every channel at reset (1..2^CNT_W-1)

Ports:
clk  input  1  system clock, rising edge only
rst_n  input  1  asynchronous active-low reset
start  input  NUM_CH  per-channel run enable (level)
ratio_load  input  NUM_CH  per-channel pulse: capture new ratio
div_ratio  input  NUM_CH*CNT_W  per-channel ratio N, channel i at [i*CNT_W +: CNT_W]
clk_out  output  NUM_CH  divided clock level, registered
tick  output  NUM_CH  1-cycle pulse on the last cycle of each period, registered
count  output  NUM_CH*CNT_W  current phase counter per channel
pending  output  NUM_CH  new ratio captured, not yet applied

Behaviour:
- Reset (async assert, sync release): count=0, clk_out=0, tick=0, pending=0, active and shadow ratio = DEFAULT_DIV, for all channels.
- Per channel, active ratio N and high length H = N - floor(N/2) (ceil(N/2)).
- start=0 at an edge: next state count=0, clk_out=0, tick=0 (immediate, synchronous stop, no period completion).
- start=1 at an edge with N>=1: count_next = (count==N-1 or channel was stopped) ? 0 : count+1. Registered clk_out = (count_next < H), registered tick = (count_next == N-1).
- The first edge with start=1 after a stop yields count=0 and clk_out=1. Period is N cycles. Duty cycle is exactly 50% for even N and H/N for odd N.
- N=1: count stays 0, clk_out stays 1, tick stays 1 while running.
- N=0: channel is disabled. count=0, clk_out=0, tick=0 regardless of start. A ratio load applies immediately if the active N is 0.
- Ratio load while stopped (or active N=0): active N takes div_ratio on that edge, pending stays 0.
- Ratio load while running: shadow takes div_ratio, pending=1. At the wrap edge (count==N-1 → 0), active takes shadow and pending clears. The new N governs the period starting at count=0.
- Load coinciding with the wrap edge: div_ratio is applied directly at that wrap, and pending stays 0.
- Repeated loads before the wrap: the last load wins.
- start deasserted with pending=1: shadow is applied on the stop edge, and pending clears.
- Reset mid-operation: all state returns to reset values at once. No partial periods are preserved.
- Channels are fully independent. There is no cross-channel phase alignment.
- No combinational path from any input to any output.

Decomposition:
- Shared package freq_div_pkg: CNT_W default, DEFAULT_DIV, and a function computing H from N.
- One sub-module, freq_div_channel: a single channel with counter, shadow/active ratio and output registers.
- Top level freq_divider_prog: a generate loop of NUM_CH freq_div_channel instances plus bus slicing only.

Test Plan:
- Reset, then start[0]=1 with N=4 → clk_out[0] pattern 1,1,0,0 repeating. tick[0] high when count=3, every 4 cycles. count runs 0,1,2,3.
- Load N=3 while stopped, then start → clk_out 1,1,0 repeating. tick when count=2. Then load N=1 while stopped and start → clk_out and tick held 1.
- Running N=4, load N=2 at count=1 → pending=1. Current period completes (count reaches 3), then pattern becomes 1,0 with tick every 2 cycles, and pending drops at the wrap edge.
- Load N=0 while stopped, with start held 1 → clk_out=0, tick=0, count=0. Load N=5 → starts immediately with 1,1,1,0,0.
- Deassert start at count=2 with N=4 → next edge count=0, clk_out=0. Reassert → restarts at count=0, clk_out=1. Assert rst_n=0 mid-period → outputs clear asynchronously, and the ratio returns to 4.
- Channel 0 at N=4 and channel 1 at N=6 running together, loading channel 1 only → channel 0 waveform is unchanged, and channel 1 changes only at its own wrap.
